// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the fifo_sync read-side stream master.
// The credit helper decides whether one more FIFO read still fits in the output buffer.
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    BUF_IDLE = 2'd0,
    BUF_POP  = 2'd1,
    BUF_PUSH = 2'd2,
    BUF_BOTH = 2'd3
  } buf_op_e;

  // The words still owed to the buffer (held plus in flight, minus the word leaving this cycle)
  // must stay below the buffer depth, so that a new read always has a slot when it lands.
  function automatic logic credit_ok(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return sum < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_buf2.sv
// Two-entry register FIFO used as the skid buffer between the FIFO read port and the stream.
// Entry 0 is always the head, so the stream data comes straight from a flop.
module stream_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_entry0;
  logic [DATA_WIDTH-1:0] r_entry1;
  occ_t                  r_occ;
  buf_op_e               w_op;

  // A pop on an empty buffer is meaningless, so it is masked before decoding.
  always_comb begin
    w_op = BUF_IDLE;
    case ({i_push, i_pop && (r_occ != 2'd0)})
      2'b01:   w_op = BUF_POP;
      2'b10:   w_op = BUF_PUSH;
      2'b11:   w_op = BUF_BOTH;
      default: w_op = BUF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_occ    <= 2'd0;
    end else begin
      case (w_op)
        BUF_PUSH: begin
          if (r_occ == 2'd0) begin
            r_entry0 <= i_data;
          end else begin
            r_entry1 <= i_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        BUF_POP: begin
          r_entry0 <= r_entry1;
          r_occ    <= r_occ - 2'd1;
        end
        BUF_BOTH: begin
          // With one entry the new word becomes the head; with two it queues behind the old tail.
          if (r_occ == 2'd1) begin
            r_entry0 <= i_data;
          end else begin
            r_entry0 <= r_entry1;
            r_entry1 <= i_data;
          end
        end
        default: begin
          r_occ <= r_occ;
        end
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_entry0;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_push |-> (r_occ != occ_t'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for fifo_sync: pops words and presents them on a valid/ready stream at
// one word per clock, hiding the FIFO's one-cycle read latency behind a two-entry buffer.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  output logic                  o_fifo_cs,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_data_out,
  input  logic                  i_fifo_empty,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [CNT_WIDTH-1:0]  o_pop_count,
  output logic                  o_busy
);

  logic [1:0]           w_occ;
  logic                 w_pop;
  logic                 w_credit;
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_pop_count;

  assign w_pop    = o_m_valid & i_m_ready;
  assign w_credit = credit_ok(w_occ, r_inflight, w_pop);

  // The FIFO strobes are gated by reset so they drop the moment reset is asserted.
  assign o_fifo_rd_en = i_rst_n & i_enable & ~i_fifo_empty & w_credit;
  assign o_busy       = (w_occ != 2'd0) | r_inflight;
  assign o_fifo_cs    = i_rst_n & (i_enable | o_busy);
  assign o_m_valid    = (w_occ != 2'd0);
  assign o_pop_count  = r_pop_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_fifo_rd_en;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pop_count <= '0;
    end else if (w_pop) begin
      r_pop_count <= r_pop_count + CNT_WIDTH'(1);
    end
  end

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (r_inflight),
    .i_data (i_fifo_data_out),
    .i_pop  (w_pop),
    .o_occ  (w_occ),
    .o_head (o_m_data)
  );

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_fifo_rd_en |-> !i_fifo_empty);

  a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_m_valid && !i_m_ready) |=> (o_m_valid && $stable(o_m_data)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a queue-based fifo_sync model (depth 8) and a
// word-count scoreboard that tracks outstanding reads and delivered order.
module tb_fifo_stream_reader;

  localparam int DW         = 32;
  localparam int CW         = 4;
  localparam int FIFO_DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          mReady = 1'b0;
  logic          fifoCs;
  logic          fifoRdEn;
  logic          fifoEmpty = 1'b1;
  logic [DW-1:0] fifoDataOut = '0;
  logic          mValid;
  logic [DW-1:0] mData;
  logic [CW-1:0] popCount;
  logic          busy;

  logic          wrReq = 1'b0;
  logic [DW-1:0] wrData = '0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] expQ[$];

  int            outstanding = 0;
  int            hsCount = 0;
  logic          prevRd = 1'b0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          expRdEn;
    logic          expValid;
    logic [DW-1:0] expData;
    logic          expBusy;
    logic [CW-1:0] expCount;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .o_fifo_cs      (fifoCs),
    .o_fifo_rd_en   (fifoRdEn),
    .i_fifo_data_out(fifoDataOut),
    .i_fifo_empty   (fifoEmpty),
    .o_m_valid      (mValid),
    .i_m_ready      (mReady),
    .o_m_data       (mData),
    .o_pop_count    (popCount),
    .o_busy         (busy)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic doWr,
                               input logic [DW-1:0] wdata);
    @(posedge clk);
    #1;
    enable = en;
    mReady = rdy;
    wrReq  = doWr;
    wrData = wdata;
  endtask

  task automatic clearModel();
    outstanding = 0;
    hsCount     = 0;
    prevRd      = 1'b0;
    prevStall   = 1'b0;
    expQ.delete();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    mReady = 1'b0;
    wrReq  = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // fifo_sync model: read and write ports act at the clock edge, empty is registered.
  always @(posedge clk) begin
    if (fifoCs && fifoRdEn && fifoQ.size() > 0) begin
      fifoDataOut <= fifoQ[0];
      expQ.push_back(fifoQ[0]);
      void'(fifoQ.pop_front());
    end
    if (wrReq && fifoQ.size() < FIFO_DEPTH) fifoQ.push_back(wrData);
    fifoEmpty <= (fifoQ.size() == 0);
  end

  // Scoreboard: outstanding = words taken from the FIFO not yet handed to the consumer.
  always @(negedge clk) begin
    logic hs;
    logic expRd;
    if (rst_n) begin
      hs    = mValid && mReady;
      expRd = enable && !fifoEmpty && ((outstanding - (hs ? 1 : 0)) < 2);
      checkOutput("rd_en", DW'(fifoRdEn), DW'(expRd));
      checkOutput("busy", DW'(busy), DW'(outstanding != 0));
      checkOutput("m_valid", DW'(mValid), DW'((outstanding - (prevRd ? 1 : 0)) != 0));
      checkOutput("fifo_cs", DW'(fifoCs), DW'(enable || (outstanding != 0)));
      checkOutput("pop_count", DW'(popCount), DW'(hsCount % (1 << CW)));
      if (fifoRdEn && fifoEmpty) checkOutput("underflow", DW'(fifoRdEn), '0);
      if (prevStall) begin
        checkOutput("hold_valid", DW'(mValid), DW'(1));
        checkOutput("hold_data", mData, prevData);
      end
      if (hs) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_word", DW'(1), DW'(0));
        end else begin
          checkOutput("order", mData, expQ[0]);
          void'(expQ.pop_front());
        end
        hsCount++;
      end
      outstanding = outstanding + (fifoRdEn ? 1 : 0) - (hs ? 1 : 0);
      prevRd      = fifoRdEn;
      prevStall   = mValid && !mReady;
      prevData    = mData;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int rdSeen;
    int validSeen;
    int cyc;
    logic [DW-1:0] firstWord;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 4'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0,   1'b1, 4'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd1,   1'b1, 4'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd10,  1'b1, 4'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd100, 1'b1, 4'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0,   1'b0, 4'd3};

    // Reset values with enable and ready high to show the strobes are forced low.
    enable = 1'b1;
    mReady = 1'b1;
    #12;
    checkOutput("rst_cs", DW'(fifoCs), '0);
    checkOutput("rst_rd_en", DW'(fifoRdEn), '0);
    checkOutput("rst_valid", DW'(mValid), '0);
    checkOutput("rst_data", mData, '0);
    checkOutput("rst_count", DW'(popCount), '0);
    checkOutput("rst_busy", DW'(busy), '0);
    doReset();

    // Test 1: latency and back-to-back delivery of 1, 10, 100.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd100);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].en, tbl[i].rdy, 1'b0, '0);
      @(negedge clk);
      checkOutput($sformatf("t1_rd_en[%0d]", i), DW'(fifoRdEn), DW'(tbl[i].expRdEn));
      checkOutput($sformatf("t1_valid[%0d]", i), DW'(mValid), DW'(tbl[i].expValid));
      if (tbl[i].expValid) checkOutput($sformatf("t1_data[%0d]", i), mData, tbl[i].expData);
      checkOutput($sformatf("t1_busy[%0d]", i), DW'(busy), DW'(tbl[i].expBusy));
      checkOutput($sformatf("t1_count[%0d]", i), DW'(popCount), DW'(tbl[i].expCount));
    end

    // Test 2: full FIFO with a stalled consumer, then full-rate drain.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, DW'(1 << i));
    rdSeen = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      if (fifoRdEn) rdSeen++;
    end
    checkOutput("t2_reads", DW'(rdSeen), DW'(2));
    checkOutput("t2_valid", DW'(mValid), DW'(1));
    checkOutput("t2_head", mData, DW'(1));
    n   = 0;
    cyc = 0;
    while (n < 8 && cyc < 30) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (mValid && mReady) begin
        checkOutput($sformatf("t2_word[%0d]", n), mData, DW'(1 << n));
        n++;
      end
      cyc++;
    end
    checkOutput("t2_cycles", DW'(cyc), DW'(8));
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("t2_count", DW'(popCount), DW'(8));

    // Test 3: empty FIFO with enable high never reads.
    rdSeen    = 0;
    validSeen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (fifoRdEn) rdSeen++;
      if (mValid) validSeen++;
    end
    checkOutput("t3_reads", DW'(rdSeen), '0);
    checkOutput("t3_valid", DW'(validSeen), '0);
    checkOutput("t3_empty", DW'(fifoEmpty), DW'(1));

    // Test 4: enable dropped right after the second read.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, DW'(32'h400 + i));
    rdSeen = 0;
    n      = 0;
    cyc    = 0;
    while (rdSeen < 2 && cyc < 10) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (fifoRdEn) rdSeen++;
      if (mValid && mReady) n++;
      cyc++;
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (mValid && mReady) n++;
    end
    checkOutput("t4_delivered", DW'(n), DW'(2));
    checkOutput("t4_busy", DW'(busy), '0);
    checkOutput("t4_left", DW'(fifoQ.size()), DW'(3));
    cyc = 0;
    while (n < 5 && cyc < 20) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (mValid && mReady) begin
        checkOutput($sformatf("t4_word[%0d]", n), mData, DW'(32'h400 + n));
        n++;
      end
      cyc++;
    end
    checkOutput("t4_total", DW'(n), DW'(5));

    // Test 5: asynchronous reset with one word buffered and one in flight.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, DW'(32'hA0 + i));
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    #3;
    checkOutput("t5_pre_valid", DW'(mValid), DW'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("t5_cs", DW'(fifoCs), '0);
    checkOutput("t5_rd_en", DW'(fifoRdEn), '0);
    checkOutput("t5_valid", DW'(mValid), '0);
    checkOutput("t5_data", mData, '0);
    checkOutput("t5_count", DW'(popCount), '0);
    checkOutput("t5_busy", DW'(busy), '0);
    enable = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    validSeen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (mValid) validSeen++;
    end
    checkOutput("t5_no_stale", DW'(validSeen), '0);
    n         = 0;
    cyc       = 0;
    firstWord = '0;
    while (n < 2 && cyc < 20) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (mValid && mReady) begin
        if (n == 0) firstWord = mData;
        n++;
      end
      cyc++;
    end
    checkOutput("t5_after", DW'(n), DW'(2));
    checkOutput("t5_first", firstWord, DW'(32'hA2));

    // Test 6: 17 words through a 4-bit counter wrap it to 1.
    doReset();
    n   = 0;
    cyc = 0;
    begin
      int written;
      written = 0;
      while (n < 17 && cyc < 200) begin
        applyStimulus(1'b1, 1'b1, (written < 17) && (fifoQ.size() < 6), $urandom);
        if (wrReq) written++;
        @(negedge clk);
        if (mValid && mReady) n++;
        cyc++;
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("t6_delivered", DW'(n), DW'(17));
    checkOutput("t6_wrap", DW'(popCount), DW'(1));

    // Random traffic against the scoreboard, then a full drain.
    doReset();
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1, $urandom);
    end
    cyc = 0;
    do begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      cyc++;
    end while ((busy || !fifoEmpty) && cyc < 100);
    checkOutput("drain_busy", DW'(busy), '0);
    checkOutput("drain_fifo", DW'(fifoQ.size()), '0);
    checkOutput("drain_scoreboard", DW'(expQ.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
